// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core.
// Arbitrates memory wait > branch flush > hazard stall, runs the
// memory-wait watchdog and keeps saturating performance counters.
module pipeline_stall_ctrl #(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt_total
);

  localparam int unsigned W_W = $clog2(MAX_WAIT + 1);
  localparam logic [W_W-1:0] W_LAST = W_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_TIMEOUT
  } state_t;

  state_t           r_state;
  logic [W_W-1:0]   r_w;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_mem_stall;
  logic w_timeout_st;
  logic w_run_like;
  logic w_branch;
  logic w_hazard;
  logic w_freeze_all;

  // Per-cycle arbitration of the stall sources; outputs follow inputs
  // in the same cycle.
  always_comb begin
    w_mem_stall  = 1'b0;
    w_timeout_st = 1'b0;
    unique case (r_state)
      S_RUN:      w_mem_stall  = mem_access && !mem_ready;
      S_MEM_WAIT: w_mem_stall  = !mem_ready;
      S_TIMEOUT:  w_timeout_st = 1'b1;
      default:    w_mem_stall  = 1'b0;
    endcase
    // A completing wait cycle behaves like a RUN cycle with no memory stall.
    w_run_like   = !w_mem_stall && !w_timeout_st;
    w_branch     = w_run_like && branch_taken;
    w_hazard     = w_run_like && !branch_taken && hazard_detected;
    w_freeze_all = w_mem_stall || w_timeout_st;
  end

  assign freeze_all     = w_freeze_all;
  assign freeze_pc      = w_freeze_all || w_hazard;
  assign flush_if_id    = w_branch;
  assign bubble_id_ex   = w_branch || w_hazard;
  assign mem_timeout    = w_timeout_st;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;
  assign wait_cnt_total = r_wait_cnt;

  // Memory-wait state machine with watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_w     <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            r_state <= S_MEM_WAIT;
            r_w     <= W_W'(1);
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            r_state <= S_RUN;
            r_w     <= '0;
          end else begin
            r_w <= r_w + W_W'(1);
            if (r_w == W_LAST) begin
              r_state <= S_TIMEOUT;
            end
          end
        end
        S_TIMEOUT: r_state <= S_TIMEOUT;
        default: begin
          r_state <= S_RUN;
          r_w     <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters, updated on the edge after the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_branch && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_freeze_all && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule
